// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pkg
//  Purpose  : Shared definitions for the UART receive path.
//             - FSM state encodings for uart_rx_ctrl.
//             - Parity-type encodings, common with the transmit side.
//             - 2-of-3 majority helper used by the oversampling sampler.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Receive FSM state encodings
    localparam int          c_STATE_W   = 3;
    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_START  = 3'd1;
    localparam logic [2:0]  c_ST_DATA   = 3'd2;
    localparam logic [2:0]  c_ST_PARITY = 3'd3;
    localparam logic [2:0]  c_ST_STOP   = 3'd4;

    // Parity_Type encodings
    localparam logic c_PARITY_EVEN = 1'b0;
    localparam logic c_PARITY_ODD  = 1'b1;

    // 2-of-3 majority vote
    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sampler
//  Purpose  : Three-tap oversampler. Captures the serial line at the
//             edge counts Prescale/2-1, Prescale/2 and Prescale/2+1 of the
//             current bit and presents the 2-of-3 majority. The output is
//             meaningful from edge Prescale/2+2 until the end of the bit.
//  Ports    : CLK          oversampling clock
//             Reset        asynchronous active-low reset
//             i_rx         serial line (already synchronized)
//             i_prescale   oversampling ratio latched for the current frame
//             i_edge_cnt   position inside the current bit (0..Prescale-1)
//             o_bit        majority-voted bit value
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRE_W = 6
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             i_rx,
    input  logic [PRE_W-1:0] i_prescale,
    input  logic [PRE_W-1:0] i_edge_cnt,
    output logic             o_bit
);

    localparam logic [PRE_W-1:0] c_ONE = PRE_W'(1);

    logic [PRE_W-1:0] w_half;
    logic [PRE_W-1:0] w_tap_lo;
    logic [PRE_W-1:0] w_tap_hi;
    logic [2:0]       r_taps;

    assign w_half   = i_prescale >> 1;
    assign w_tap_lo = w_half - c_ONE;
    assign w_tap_hi = w_half + c_ONE;

    // Each bit period overwrites all three taps before the vote is used,
    // so no explicit clearing between bits is needed.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_taps <= '0;
        end else begin
            if (i_edge_cnt == w_tap_lo) r_taps[0] <= i_rx;
            if (i_edge_cnt == w_half)   r_taps[1] <= i_rx;
            if (i_edge_cnt == w_tap_hi) r_taps[2] <= i_rx;
        end
    end

    assign o_bit = majority3(r_taps);

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : UART receive controller. Detects the start bit, oversamples
//             RX_IN with a majority vote, deserializes DATA_W bits LSB
//             first, checks optional parity and the stop bit, and delivers
//             the byte with a one-cycle Data_valid pulse.
//  Ports    : CLK           oversampling clock (Prescale cycles per bit)
//             Reset         asynchronous active-low reset
//             RX_IN         serial line, idle high, externally synchronized
//             Prescale      oversampling ratio (8, 16 or 32)
//             Parity_EN     1 = frame carries a parity bit
//             Parity_Type   0 = even, 1 = odd
//             P_DATA        last good received byte
//             Data_valid    1-cycle pulse, P_DATA holds a good frame
//             Parity_error  1-cycle pulse at the end of a bad parity bit
//             Stop_error    1-cycle pulse at the end of a bad stop bit
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PRE_W  = 6
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              RX_IN,
    input  logic [PRE_W-1:0]  Prescale,
    input  logic              Parity_EN,
    input  logic              Parity_Type,
    output logic [DATA_W-1:0] P_DATA,
    output logic              Data_valid,
    output logic              Parity_error,
    output logic              Stop_error
);

    localparam int                 c_BIT_W    = $clog2(DATA_W);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_W - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [PRE_W-1:0]   c_EDGE_ONE = PRE_W'(1);
    localparam logic [PRE_W-1:0]   c_EDGE_TWO = PRE_W'(2);

    logic [c_STATE_W-1:0] r_state;
    logic [PRE_W-1:0]     r_edge_cnt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [PRE_W-1:0]     r_prescale;
    logic                 r_par_en;
    logic                 r_par_type;
    logic [DATA_W-1:0]    r_shift;
    logic                 r_par_bad;
    logic [DATA_W-1:0]    r_p_data;
    logic                 r_data_valid;
    logic                 r_parity_error;
    logic                 r_stop_error;

    logic                 w_sample_bit;
    logic                 w_last_edge;
    logic                 w_pre_last;
    logic                 w_decide;
    logic                 w_par_mismatch;

    uart_rx_sampler #(
        .PRE_W (PRE_W)
    ) u_sampler (
        .CLK        (CLK),
        .Reset      (Reset),
        .i_rx       (RX_IN),
        .i_prescale (r_prescale),
        .i_edge_cnt (r_edge_cnt),
        .o_bit      (w_sample_bit)
    );

    assign w_last_edge    = (r_edge_cnt == r_prescale - c_EDGE_ONE);
    // Outputs are registered, so pulses meant to be visible during the
    // last oversample of a bit are decided one edge earlier. For every
    // legal Prescale, edge Prescale-2 is at or after the first edge where
    // the majority vote is valid (Prescale/2+2).
    assign w_pre_last     = (r_edge_cnt == r_prescale - c_EDGE_TWO);
    assign w_decide       = (r_edge_cnt == (r_prescale >> 1) + c_EDGE_TWO);
    assign w_par_mismatch = ((^r_shift) ^ r_par_type) != w_sample_bit;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state        <= c_ST_IDLE;
            r_edge_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_prescale     <= '0;
            r_par_en       <= 1'b0;
            r_par_type     <= c_PARITY_EVEN;
            r_shift        <= '0;
            r_par_bad      <= 1'b0;
            r_p_data       <= '0;
            r_data_valid   <= 1'b0;
            r_parity_error <= 1'b0;
            r_stop_error   <= 1'b0;
        end else begin
            r_data_valid   <= 1'b0;
            r_parity_error <= 1'b0;
            r_stop_error   <= 1'b0;

            if (r_state != c_ST_IDLE) begin
                r_edge_cnt <= w_last_edge ? '0 : r_edge_cnt + c_EDGE_ONE;
            end

            case (r_state)
                c_ST_IDLE: begin
                    // Frame configuration is frozen from the detection cycle on.
                    r_edge_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_par_bad  <= 1'b0;
                    r_prescale <= Prescale;
                    r_par_en   <= Parity_EN;
                    r_par_type <= Parity_Type;
                    if (!RX_IN) begin
                        r_state <= c_ST_START;
                    end
                end

                c_ST_START: begin
                    if (w_decide && w_sample_bit) begin
                        r_state <= c_ST_IDLE;      // glitch, not a start bit
                    end else if (w_last_edge) begin
                        r_state <= c_ST_DATA;
                    end
                end

                c_ST_DATA: begin
                    if (w_last_edge) begin
                        r_shift   <= {w_sample_bit, r_shift[DATA_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_state <= r_par_en ? c_ST_PARITY : c_ST_STOP;
                        end
                    end
                end

                c_ST_PARITY: begin
                    if (w_pre_last) begin
                        r_par_bad      <= w_par_mismatch;
                        r_parity_error <= w_par_mismatch;
                    end
                    if (w_last_edge) begin
                        r_state <= c_ST_STOP;
                    end
                end

                c_ST_STOP: begin
                    if (w_pre_last) begin
                        if (!w_sample_bit) begin
                            r_stop_error <= 1'b1;
                        end else if (!r_par_bad) begin
                            r_p_data     <= r_shift;
                            r_data_valid <= 1'b1;
                        end
                    end
                    if (w_last_edge) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign P_DATA       = r_p_data;
    assign Data_valid   = r_data_valid;
    assign Parity_error = r_parity_error;
    assign Stop_error   = r_stop_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_ctrl
//  Purpose  : Self-checking bench for uart_rx_ctrl. Table of frames with
//             expected pulses and P_DATA, a pulse scoreboard fed when a
//             frame is driven, and hand-written glitch, back-to-back and
//             mid-frame reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int c_DATA_W = 8;
    localparam int c_PRE_W  = 6;
    localparam int c_NV     = 7;

    logic                CLK = 1'b0;
    logic                Reset;
    logic                RX_IN;
    logic [c_PRE_W-1:0]  Prescale;
    logic                Parity_EN;
    logic                Parity_Type;
    logic [c_DATA_W-1:0] P_DATA;
    logic                Data_valid;
    logic                Parity_error;
    logic                Stop_error;

    uart_rx_ctrl #(
        .DATA_W (c_DATA_W),
        .PRE_W  (c_PRE_W)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .Parity_EN    (Parity_EN),
        .Parity_Type  (Parity_Type),
        .P_DATA       (P_DATA),
        .Data_valid   (Data_valid),
        .Parity_error (Parity_error),
        .Stop_error   (Stop_error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         pre;
        bit         pen;
        bit         ptype;
        logic [7:0] data;
        bit         pbit;      // parity bit value actually driven
        bit         stop;      // stop bit value actually driven
        bit         exp_dv;
        bit         exp_pe;
        bit         exp_se;
        logic [7:0] exp_pdata; // P_DATA required after the frame
    } vec_t;

    typedef struct packed {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] d;
    } ev_t;

    vec_t vecs [c_NV];
    ev_t  sb   [$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    int   dv_cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    // Scoreboard consumer: every output pulse must match the head event.
    initial begin
        ev_t e;
        forever begin
            @(negedge CLK);
            if (Data_valid || Parity_error || Stop_error) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse got dv=%0b pe=%0b se=%0b p_data=0x%0h want no pulse",
                             Data_valid, Parity_error, Stop_error, P_DATA);
                end else begin
                    e = sb.pop_front();
                    if ({Data_valid, Parity_error, Stop_error} !== {e.dv, e.pe, e.se} ||
                        (e.dv && P_DATA !== e.d)) begin
                        failures++;
                        $display("FAIL pulse got dv=%0b pe=%0b se=%0b p_data=0x%0h want dv=%0b pe=%0b se=%0b p_data=0x%0h",
                                 Data_valid, Parity_error, Stop_error, P_DATA, e.dv, e.pe, e.se, e.d);
                    end
                end
                if (Data_valid) dv_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic hold(input bit v, input int n);
        RX_IN = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input int pre, input bit pen, input bit ptype,
                              input logic [7:0] data, input bit pbit, input bit stop);
        Prescale    = c_PRE_W'(pre);
        Parity_EN   = pen;
        Parity_Type = ptype;
        start_cyc   = cyc + 1;   // posedge that detects the start bit
        hold(1'b0, pre);
        for (int i = 0; i < 8; i++) hold(data[i], pre);
        if (pen) hold(pbit, pre);
        hold(stop, pre);
        RX_IN = 1'b1;
    endtask

    initial begin
        Reset = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; Parity_EN = 1'b0; Parity_Type = 1'b0;

        //          pre pen pt data   pb st  dv pe se pdata
        vecs[0] = '{ 8, 1, 0, 8'hA5, 0, 1,  1, 0, 0, 8'hA5};
        vecs[1] = '{16, 0, 0, 8'h3C, 0, 1,  1, 0, 0, 8'h3C};
        // 0x01 has one set bit, so odd parity wants 0; drive 1 to corrupt it
        vecs[2] = '{ 8, 1, 1, 8'h01, 1, 1,  0, 1, 0, 8'h3C};
        vecs[3] = '{32, 0, 0, 8'hFF, 0, 0,  0, 0, 1, 8'h3C};
        vecs[4] = '{32, 1, 1, 8'h81, 0, 0,  0, 1, 1, 8'h3C};
        vecs[5] = '{16, 1, 0, 8'h6B, 1, 1,  1, 0, 0, 8'h6B};
        vecs[6] = '{32, 1, 1, 8'h0F, 1, 1,  1, 0, 0, 8'h0F};

        repeat (3) @(negedge CLK);
        check("reset_p_data",       32'(P_DATA),       32'h0);
        check("reset_data_valid",   32'(Data_valid),   32'h0);
        check("reset_parity_error", 32'(Parity_error), 32'h0);
        check("reset_stop_error",   32'(Stop_error),   32'h0);
        Reset = 1'b1;
        repeat (4) @(negedge CLK);

        for (int v = 0; v < c_NV; v++) begin
            if (vecs[v].exp_pe) sb.push_back('{dv:1'b0, pe:1'b1, se:1'b0, d:8'h00});
            if (vecs[v].exp_se) sb.push_back('{dv:1'b0, pe:1'b0, se:1'b1, d:8'h00});
            if (vecs[v].exp_dv) sb.push_back('{dv:1'b1, pe:1'b0, se:1'b0, d:vecs[v].exp_pdata});
            send_frame(vecs[v].pre, vecs[v].pen, vecs[v].ptype, vecs[v].data, vecs[v].pbit, vecs[v].stop);
            repeat (4) @(negedge CLK);
            check($sformatf("pending_pulses_v%0d", v), 32'(sb.size()), 32'h0);
            check($sformatf("p_data_v%0d", v), 32'(P_DATA), 32'(vecs[v].exp_pdata));
            if (vecs[v].exp_dv) begin
                // rise at the last oversample of the stop bit
                check($sformatf("latency_v%0d", v), 32'(dv_cyc - start_cyc),
                      32'((10 + int'(vecs[v].pen)) * vecs[v].pre - 1));
            end
            sb.delete();
        end

        // Glitch: two low cycles must be rejected silently
        Prescale = 6'd8; Parity_EN = 1'b0;
        hold(1'b0, 2);
        hold(1'b1, 20);
        check("glitch_p_data", 32'(P_DATA), 32'h0F);

        // Back-to-back frames with no idle bit between them
        sb.push_back('{dv:1'b1, pe:1'b0, se:1'b0, d:8'h55});
        sb.push_back('{dv:1'b1, pe:1'b0, se:1'b0, d:8'hAA});
        send_frame(8, 0, 0, 8'h55, 0, 1);
        send_frame(8, 0, 0, 8'hAA, 0, 1);
        repeat (4) @(negedge CLK);
        check("b2b_pending", 32'(sb.size()), 32'h0);
        check("b2b_p_data", 32'(P_DATA), 32'hAA);
        sb.delete();

        // Reset during data bit 4 aborts the frame and clears outputs at once
        hold(1'b0, 8);
        for (int i = 0; i < 4; i++) hold(i[0], 8);
        hold(1'b0, 3);
        Reset = 1'b0;
        #1;
        check("midreset_p_data",     32'(P_DATA),       32'h0);
        check("midreset_data_valid", 32'(Data_valid),   32'h0);
        check("midreset_par_err",    32'(Parity_error), 32'h0);
        check("midreset_stop_err",   32'(Stop_error),   32'h0);
        @(negedge CLK);
        hold(1'b1, 3);
        Reset = 1'b1;
        hold(1'b1, 16);
        sb.push_back('{dv:1'b1, pe:1'b0, se:1'b0, d:8'h7E});
        send_frame(8, 0, 0, 8'h7E, 0, 1);
        repeat (4) @(negedge CLK);
        check("post_reset_pending", 32'(sb.size()), 32'h0);
        check("post_reset_p_data", 32'(P_DATA), 32'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
